// File: rtl/debounced_updown_counter.sv
// rtl/debounced_updown_counter.sv - two-button up/down counter with synchronisers, debounce and wrap/saturate
// Each button is synchronised and debounced; a debounced rising edge steps the counter by STEP.
module debounced_updown_counter #(
    parameter int WIDTH           = 8,
    parameter int STEP            = 1,
    parameter int RESET_VALUE     = 0,
    parameter int SATURATE        = 0,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             BTN0,
    input  logic             BTN1,
    output logic [WIDTH-1:0] LD,
    output logic             EVT_DOWN,
    output logic             EVT_UP,
    output logic             AT_MIN,
    output logic             AT_MAX
);

    localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH:0] STEP_W   = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

    logic [SYNC_STAGES-1:0] sync0;
    logic [SYNC_STAGES-1:0] sync1;
    logic [SYNC_STAGES-1:0] primed_sr;
    logic                   primed;
    logic [1:0]             s;
    logic [1:0]             stable;
    logic [1:0]             stable_d;
    logic [1:0]             armed;
    logic [CW-1:0]          cnt [2];
    logic [1:0]             press;
    logic                   dn;
    logic                   up;
    logic [WIDTH:0]         sum;
    logic [WIDTH:0]         diff;
    logic [WIDTH-1:0]       up_val;
    logic [WIDTH-1:0]       dn_val;

    // primed_sr marks when the synchroniser holds real samples rather than reset zeros
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sync0     <= '0;
            sync1     <= '0;
            primed_sr <= '0;
        end else begin
            sync0     <= {sync0[SYNC_STAGES-2:0], BTN0};
            sync1     <= {sync1[SYNC_STAGES-2:0], BTN1};
            primed_sr <= {primed_sr[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign primed = primed_sr[SYNC_STAGES-1];
    assign s      = {sync1[SYNC_STAGES-1], sync0[SYNC_STAGES-1]};

    // A button only arms after a genuine low sample, so one held through reset never presses
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            stable   <= '0;
            stable_d <= '0;
            armed    <= '0;
            cnt[0]   <= '0;
            cnt[1]   <= '0;
        end else begin
            stable_d <= stable;
            for (int i = 0; i < 2; i++) begin
                if (primed && !s[i]) begin
                    armed[i] <= 1'b1;
                end
                if (s[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= s[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign press = stable & ~stable_d & armed;
    assign dn    = press[0];
    assign up    = press[1];

    always_comb begin
        sum    = {1'b0, LD} + STEP_W;
        diff   = {1'b0, LD} - STEP_W;
        up_val = sum[WIDTH-1:0];
        dn_val = diff[WIDTH-1:0];
        if (SATURATE != 0) begin
            if (sum[WIDTH])  up_val = MAX_VAL;
            if (diff[WIDTH]) dn_val = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            LD       <= RST_VAL;
            EVT_UP   <= 1'b0;
            EVT_DOWN <= 1'b0;
        end else begin
            EVT_UP   <= up & ~dn;
            EVT_DOWN <= dn & ~up;
            if (up && !dn) begin
                LD <= up_val;
            end else if (dn && !up) begin
                LD <= dn_val;
            end
        end
    end

    assign AT_MIN = (LD == '0);
    assign AT_MAX = (LD == MAX_VAL);

endmodule
